// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a req/ack memory port,
// buffers DEPTH {ins, pc} entries and hands the oldest to execute; redirects flush it.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rstd,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_data,
    output logic          ins_valid,
    output logic [31:0]   ins,
    output logic [31:0]   pc,
    input  logic          ins_ready,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic          req_reg, req_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          discard_reg, discard_next;

    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];

    logic          ack_fire;
    logic          hold_req;
    logic          push;
    logic          pop;
    logic          unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign ack_fire = req_reg && imem_ack;
    assign hold_req = req_reg && !imem_ack;
    assign push     = ack_fire && !discard_reg && !redirect;
    assign pop      = (count_reg != '0) && ins_ready && !redirect;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        discard_next  = discard_reg;
        if (redirect) begin
            head_next     = '0;
            tail_next     = '0;
            count_next    = '0;
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            // A request still waiting for its ack must be drained and its data dropped.
            discard_next  = hold_req;
        end else begin
            if (push) begin
                tail_next     = tail_reg + 1'b1;
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (pop) begin
                head_next = head_reg + 1'b1;
            end
            count_next = count_reg + CW'(push) - CW'(pop);
            if (ack_fire && discard_reg) begin
                discard_next = 1'b0;
            end
        end
        // Counting only committed entries is enough: a new request is issued only
        // when a slot is free and nothing else can fill it before the ack.
        req_next  = hold_req || (!redirect && (count_next < CW'(DEPTH)));
        addr_next = hold_req ? addr_reg : fetch_pc_next[AW-1:0];
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            fetch_pc_reg <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            req_reg      <= 1'b0;
            addr_reg     <= '0;
            discard_reg  <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            req_reg      <= req_next;
            addr_reg     <= addr_next;
            discard_reg  <= discard_next;
        end
    end

    // Payload storage needs no reset; the outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[tail_reg] <= imem_data;
            pc_mem[tail_reg]  <= fetch_pc_reg;
        end
    end

    assign imem_req  = req_reg;
    assign imem_addr = addr_reg;
    assign ins_valid = (count_reg != '0);
    assign ins       = ins_valid ? ins_mem[head_reg] : 32'd0;
    assign pc        = ins_valid ? pc_mem[head_reg]  : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rstd = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_data = '0;
    logic          ins_valid;
    logic [31:0]   ins;
    logic [31:0]   pc;
    logic          ins_ready = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstd(rstd),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .ins_valid(ins_valid), .ins(ins), .pc(pc),
        .ins_ready(ins_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    bit          m_req;
    logic [31:0] m_addr;
    logic [31:0] m_fetch;
    bit          m_stale;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        e_ins = (q.size() != 0) ? q[0].ins : 32'd0;
        e_pc  = (q.size() != 0) ? q[0].pc  : 32'd0;
        check("model_req", 32'(imem_req), 32'(m_req));
        if (m_req) check("model_addr", 32'(imem_addr), 32'(m_addr[AW-1:0]));
        check("model_valid", 32'(ins_valid), 32'(q.size() != 0));
        check("model_ins", ins, e_ins);
        check("model_pc", pc, e_pc);
    endtask

    // Memory-side view: one outstanding request at a known address, possibly stale.
    task automatic model_step(input bit a, input bit r, input bit rd,
                              input logic [31:0] rpc, input logic [31:0] d);
        bit acked;
        bit do_pop;
        bit do_push;
        acked = m_req && a;
        if (rd) begin
            q.delete();
            m_fetch = {rpc[31:2], 2'b00};
            m_stale = m_req && !a;
        end else begin
            do_pop  = (q.size() != 0) && r;
            do_push = acked && !m_stale;
            if (acked && m_stale) m_stale = 1'b0;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back('{ins: d, pc: m_addr});
                m_fetch = m_addr + 32'd4;
            end
        end
        if (m_req && !a) begin
            m_req = 1'b1;
        end else if (!rd && q.size() < DEPTH) begin
            m_req  = 1'b1;
            m_addr = m_fetch;
        end else begin
            m_req = 1'b0;
        end
    endtask

    task automatic cycle(input bit a, input bit r, input bit rd, input logic [31:0] rpc);
        logic [31:0] d;
        d = $urandom();
        imem_ack    = a;
        ins_ready   = r;
        redirect    = rd;
        redirect_pc = rpc;
        imem_data   = d;
        @(posedge clk);
        model_step(a, r, rd, rpc, d);
        @(negedge clk);
        compare_model();
        $display("cyc ack=%0d rdy=%0d redir=%0d rpc=%08h | req=%0d addr=%02h valid=%0d pc=%08h ins=%08h",
                 a, r, rd, rpc, imem_req, imem_addr, ins_valid, pc, ins);
    endtask

    task automatic do_reset();
        rstd = 1'b0;
        imem_ack = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_data = '0;
        q.delete();
        m_req = 1'b0; m_addr = '0; m_fetch = '0; m_stale = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(ins_valid), 32'd0);
        rstd = 1'b1;
        compare_model();
    endtask

    initial begin
        // Streaming with ack and ready held high
        do_reset();
        cycle(1, 1, 0, 0);
        check("stream_req0", 32'(imem_req), 32'd1);
        check("stream_addr0", 32'(imem_addr), 32'h00);
        check("stream_valid0", 32'(ins_valid), 32'd0);
        cycle(1, 1, 0, 0);
        check("stream_pc0", pc, 32'h0);
        check("stream_addr1", 32'(imem_addr), 32'h04);
        cycle(1, 1, 0, 0);
        check("stream_pc1", pc, 32'h4);
        cycle(1, 1, 0, 0);
        check("stream_pc2", pc, 32'h8);

        // Fill with ready low, then one pop
        do_reset();
        repeat (5) cycle(1, 0, 0, 0);
        check("fill_req_off", 32'(imem_req), 32'd0);
        check("fill_head_pc", pc, 32'h0);
        cycle(1, 0, 0, 0);
        check("fill_req_still_off", 32'(imem_req), 32'd0);
        cycle(1, 1, 0, 0);
        check("fill_pop_pc", pc, 32'h4);
        check("fill_req_on", 32'(imem_req), 32'd1);
        check("fill_addr", 32'(imem_addr), 32'h10);

        // Redirect with an outstanding request, then back-to-back redirects
        do_reset();
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 1, 32'h40);
        check("disc_addr_held", 32'(imem_addr), 32'h08);
        check("disc_valid", 32'(ins_valid), 32'd0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        check("disc_new_addr", 32'(imem_addr), 32'h40);
        check("disc_valid_after_drop", 32'(ins_valid), 32'd0);
        cycle(1, 1, 0, 0);
        check("disc_head_pc", pc, 32'h40);
        cycle(0, 1, 1, 32'h80);
        cycle(0, 1, 1, 32'hC0);
        cycle(1, 1, 0, 0);
        check("b2b_addr", 32'(imem_addr), 32'hC0);
        check("b2b_valid", 32'(ins_valid), 32'd0);
        cycle(1, 1, 0, 0);
        check("b2b_pc0", pc, 32'hC0);
        cycle(1, 1, 0, 0);
        check("b2b_pc1", pc, 32'hC4);

        // Redirect to an unaligned target while popping with three entries
        do_reset();
        repeat (4) cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 32'h23);
        check("unal_valid", 32'(ins_valid), 32'd0);
        check("unal_req", 32'(imem_req), 32'd0);
        cycle(0, 1, 0, 0);
        check("unal_addr", 32'(imem_addr), 32'h20);

        // Address wrap at the top of the 32-bit space
        do_reset();
        cycle(0, 1, 0, 0);
        cycle(1, 1, 1, 32'hFFFF_FFFC);
        check("wrap_req_gap", 32'(imem_req), 32'd0);
        cycle(0, 1, 0, 0);
        check("wrap_addr0", 32'(imem_addr), 32'hFC);
        cycle(1, 1, 0, 0);
        check("wrap_pc0", pc, 32'hFFFF_FFFC);
        check("wrap_addr1", 32'(imem_addr), 32'h00);
        cycle(1, 1, 0, 0);
        check("wrap_pc1", pc, 32'h0000_0000);
        check("wrap_addr2", 32'(imem_addr), 32'h04);
        cycle(1, 1, 0, 0);
        check("wrap_pc2", pc, 32'h0000_0004);

        // Asynchronous reset between clock edges
        do_reset();
        repeat (3) cycle(1, 0, 0, 0);
        check("areset_pre_valid", 32'(ins_valid), 32'd1);
        check("areset_pre_req", 32'(imem_req), 32'd1);
        #2 rstd = 1'b0;
        #1;
        check("areset_req", 32'(imem_req), 32'd0);
        check("areset_addr", 32'(imem_addr), 32'd0);
        check("areset_valid", 32'(ins_valid), 32'd0);
        check("areset_ins", ins, 32'd0);
        check("areset_pc", pc, 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          a, r, rd;
            logic [31:0] rpc;
            a   = ($urandom % 4) != 0;
            r   = ($urandom % 3) != 0;
            rd  = ($urandom % 16) == 0;
            rpc = $urandom();
            if (($urandom % 8) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom % 16);
            cycle(a, r, rd, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
